// File: rtl/acc_feeder.sv
// Collects signed samples into 4-element vectors and hands them to an accelerator
// over a valid/ready pair; s_last closes a vector early with zero padding.
module acc_feeder #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] X1,
   output logic [DATA_W-1:0] X2,
   output logic [DATA_W-1:0] X3,
   output logic [DATA_W-1:0] X4,
   output logic              valid,
   input  logic              ready,
   output logic [CNT_W-1:0]  vec_count
);

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_PEND    = 1'b1;

   logic              state;
   logic [1:0]        idx;
   logic [DATA_W-1:0] slot [4];
   logic [DATA_W-1:0] vec  [4];
   logic              accept;
   logic              handoff;
   logic              out_free;
   logic              complete;
   logic              load;

   assign s_ready = (state == ST_COLLECT) && !arst;

   always_comb begin
      accept   = s_valid && s_ready;
      handoff  = valid && ready;
      out_free = !valid || ready;
      complete = accept && ((idx == 2'd3) || s_last);
      load     = (complete && out_free) || ((state == ST_PEND) && out_free);
      // Collector contents with the incoming sample merged in; slots past it are forced to zero.
      for (int i = 0; i < 4; i++) begin
         vec[i] = slot[i];
         if (accept && (idx == 2'(i))) begin
            vec[i] = s_data;
         end else if (accept && (2'(i) > idx)) begin
            vec[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state     <= ST_COLLECT;
         idx       <= 2'd0;
         valid     <= 1'b0;
         vec_count <= '0;
         X1        <= '0;
         X2        <= '0;
         X3        <= '0;
         X4        <= '0;
         for (int i = 0; i < 4; i++) begin
            slot[i] <= '0;
         end
      end else begin
         if (handoff) begin
            vec_count <= vec_count + 1'b1;
         end

         if (load) begin
            X1    <= vec[0];
            X2    <= vec[1];
            X3    <= vec[2];
            X4    <= vec[3];
            valid <= 1'b1;
         end else if (handoff) begin
            valid <= 1'b0;
         end

         case (state)
            ST_COLLECT: begin
               if (complete) begin
                  idx <= 2'd0;
                  if (out_free) begin
                     for (int i = 0; i < 4; i++) begin
                        slot[i] <= '0;
                     end
                  end else begin
                     for (int i = 0; i < 4; i++) begin
                        slot[i] <= vec[i];
                     end
                     state <= ST_PEND;
                  end
               end else if (accept) begin
                  slot[idx] <= s_data;
                  idx       <= idx + 2'd1;
               end
            end
            default: begin
               if (out_free) begin
                  for (int i = 0; i < 4; i++) begin
                     slot[i] <= '0;
                  end
                  idx   <= 2'd0;
                  state <= ST_COLLECT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: vector table, multi-cycle sequences and a
// randomized run scored against a sample-list reference model.
module tb_acc_feeder;

   logic        clk;
   logic        arst;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [7:0]  X1, X2, X3, X4;
   logic        valid;
   logic        ready;
   logic [15:0] vec_count;

   acc_feeder #(.DATA_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .arst      (arst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .X1        (X1),
      .X2        (X2),
      .X3        (X3),
      .X4        (X4),
      .valid     (valid),
      .ready     (ready),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  n;
      logic [31:0] s;
      logic        last;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [6];
   int          n_chk = 0;
   int          n_fail = 0;
   int          hcount = 0;
   logic [15:0] mcnt = '0;
   logic [7:0]  cur [$];
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Reference model: a vector is the list of accepted samples, closed at 4 or on s_last.
   task automatic tick();
      logic        acc;
      logic        ho;
      logic [31:0] v;
      acc = s_valid && s_ready;
      ho  = valid && ready;
      if (arst) begin
         cur.delete();
         exp_q.delete();
         mcnt = '0;
      end else begin
         if (ho) begin
            hcount++;
            mcnt = mcnt + 16'd1;
            if (exp_q.size() == 0) begin
               chk("unexpected_handoff", {X1, X2, X3, X4}, 32'hxxxxxxxx);
            end else begin
               chk("handoff_vec", {X1, X2, X3, X4}, exp_q.pop_front());
            end
         end
         if (acc) begin
            cur.push_back(s_data);
            if (cur.size() == 4 || s_last) begin
               v = '0;
               for (int i = 0; i < cur.size(); i++) v[31-8*i -: 8] = cur[i];
               exp_q.push_back(v);
               cur.delete();
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic feed(input logic [7:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = s_ready;
         tick();
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL feed_timeout: sample %h not accepted within 20 cycles", d);
      end
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      arst    = 1'b1;
      tick();
      chk("rst_sready", {31'd0, s_ready}, 32'd0);
      chk("rst_outputs", {X1, X2, X3, X4}, 32'd0);
      chk("rst_valid_cnt", {15'd0, valid, vec_count}, 32'd0);
      arst = 1'b0;
      #1;
      chk("rst_release_sready", {31'd0, s_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] w;
      int          stalls;
      arst    = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      ready   = 1'b0;
      tbl[0] = '{3'd4, 32'h010203FC, 1'b0, 32'h010203FC};
      tbl[1] = '{3'd2, 32'h05FA0000, 1'b1, 32'h05FA0000};
      tbl[2] = '{3'd4, 32'h090A0B0C, 1'b0, 32'h090A0B0C};
      tbl[3] = '{3'd1, 32'h07000000, 1'b1, 32'h07000000};
      tbl[4] = '{3'd4, 32'h01010101, 1'b1, 32'h01010101};
      tbl[5] = '{3'd3, 32'h807FFF00, 1'b1, 32'h807FFF00};
      @(negedge clk);

      // Table-driven vectors with the accelerator always ready.
      do_reset();
      ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         w = tbl[k].s;
         for (int i = 0; i < int'(tbl[k].n); i++) begin
            feed(w[31-8*i -: 8], tbl[k].last && (i == int'(tbl[k].n) - 1));
         end
         s_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", k), {31'd0, valid}, 32'd1);
         chk($sformatf("tbl%0d_vec", k), {X1, X2, X3, X4}, tbl[k].exp);
         tick();
         chk($sformatf("tbl%0d_cleared", k), {31'd0, valid}, 32'd0);
      end
      tick();
      chk("tbl_no_extra_vec", {31'd0, valid}, 32'd0);
      chk("tbl_vec_count", {16'd0, vec_count}, 32'd6);

      // Backpressure: second vector parks in PEND until ready rises.
      do_reset();
      ready = 1'b0;
      for (int v = 1; v <= 8; v++) feed(8'(v), 1'b0);
      s_valid = 1'b0;
      s_data  = 8'hAA;
      chk("pend_sready", {31'd0, s_ready}, 32'd0);
      chk("pend_held_vec", {X1, X2, X3, X4}, 32'h01020304);
      chk("pend_held_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      tick();
      chk("pend_next_vec", {X1, X2, X3, X4}, 32'h05060708);
      chk("pend_next_sready", {31'd0, s_ready}, 32'd1);
      tick();
      chk("pend_final_valid", {31'd0, valid}, 32'd0);
      chk("pend_vec_count", {16'd0, vec_count}, 32'd2);

      // Reset mid-vector drops the partial vector.
      do_reset();
      ready = 1'b1;
      feed(8'd20, 1'b0);
      feed(8'd21, 1'b0);
      s_valid = 1'b0;
      do_reset();
      ready = 1'b1;
      for (int v = 3; v <= 6; v++) feed(8'(v), 1'b0);
      s_valid = 1'b0;
      chk("midrst_vec", {X1, X2, X3, X4}, 32'h03040506);
      tick();
      chk("midrst_vec_count", {16'd0, vec_count}, 32'd1);

      // Random traffic with random backpressure, scored by the model.
      for (int c = 0; c < 3000; c++) begin
         s_valid = 1'($urandom_range(1));
         s_data  = 8'($urandom);
         s_last  = ($urandom_range(3) == 0);
         ready   = 1'($urandom_range(1));
         tick();
      end
      s_valid = 1'b0;
      ready   = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      chk("rand_drained", exp_q.size(), 32'd0);
      chk("rand_vec_count", {16'd0, vec_count}, {16'd0, mcnt});

      // Full-rate run to the counter wrap.
      do_reset();
      hcount  = 0;
      stalls  = 0;
      ready   = 1'b1;
      s_valid = 1'b1;
      for (int c = 0; c < 99000 && hcount < 65536; c++) begin
         s_data = 8'($urandom);
         s_last = ($urandom_range(15) != 0);
         if (!s_ready) stalls++;
         tick();
      end
      chk("full_handoffs", hcount, 32'd65536);
      chk("full_wrap_count", {16'd0, vec_count}, 32'd0);
      chk("full_no_stall", stalls, 32'd0);
      s_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("full_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_feeder.md
ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 Parameter: DATA_W, 8, sample width in bits (signed two's complement); all sample ports are DATA_W wide.
REQ-002 Parameter: CNT_W, 16, width of vec_count.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: arst  in  1  reset, synchronous, active-high.
REQ-005 Port: s_data  in  DATA_W  upstream sample, signed.
REQ-006 Port: s_valid  in  1  upstream sample valid.
REQ-007 Port: s_last  in  1  marks the sample as the final one of a frame; qualified by s_valid.
REQ-008 Port: s_ready  out  1  feeder can accept a sample this cycle.
REQ-009 Port: X1, X2, X3, X4  out  DATA_W each  vector to accelerator; X1 holds the first sample collected.
REQ-010 Port: valid  out  1  vector on X1..X4 is valid (drives accelerator valid).
REQ-011 Port: ready  in  1  accelerator accepts vector (driven by accelerator ready).
REQ-012 Port: vec_count  out  CNT_W  number of vectors handed off since reset.

Function
REQ-013 Sample accepted on an edge where s_valid && s_ready; vector handed off on an edge where valid && ready.
REQ-014 Collector: four slots plus a 2-bit index; an accepted sample is written to the slot at the index, and the index increments.
REQ-015 Vector complete when the sample is accepted at index 3, or when an accepted sample has s_last=1 at any index.
REQ-016 On s_last at index k<3: slots k+1..3 are zero in the completed vector; no extra vector is generated for s_last at index 3.
REQ-017 Collector FSM states: COLLECT, PEND; s_ready = 1 only in COLLECT and arst low.
REQ-018 COLLECT, vector completes, output register free (valid=0, or valid && ready on the same edge): vector loads into output register on that edge, valid=1 next cycle, index->0, slots->0, stay COLLECT.
REQ-019 COLLECT, vector completes, output register busy (valid && !ready): go to PEND holding the collected vector.
REQ-020 PEND: on the first edge with valid=0 or ready=1, load the pending vector, clear the collector, index->0, go to COLLECT.
REQ-021 Latency: the sample completing a vector is accepted at edge N, and valid=1 with the new X1..X4 is visible after edge N when the output is free.
REQ-022 While valid && !ready: X1..X4 and valid are held stable.
REQ-023 A handoff with no new vector loading on the same edge clears valid.
REQ-024 Throughput: sustains 1 sample/cycle indefinitely while ready=1 whenever valid=1.
REQ-025 vec_count increments by 1 on each handoff and wraps from 2^CNT_W-1 to 0.
REQ-026 Samples are stored unmodified; the block does no arithmetic on data.
REQ-027 s_data and s_last are ignored when no sample is accepted.

Reset
REQ-028 On an edge with arst=1: state=COLLECT, index=0, all slots=0, X1..X4=0, valid=0, vec_count=0.
REQ-029 s_ready=0 while arst=1, and it is 1 in the first cycle after reset is released.
REQ-030 Reset mid-vector or in PEND discards the partial or pending vector and any held output vector without handing it off.

Verification
REQ-031 Reset; stream 1, 2, 3, -4 on consecutive cycles, ready=1 -> valid=1 the cycle after -4 is accepted, X=(1,2,3,-4), vec_count=1 after the handoff.
REQ-032 ready=0; stream samples 1..8 -> X=(1,2,3,4) held, s_ready=0 after sample 8 (PEND); raise ready -> the next cycle shows X=(5,6,7,8), s_ready=1, and vec_count ends at 2 after both handoffs.
REQ-033 Stream 5, then -6 with s_last=1 -> X=(5,-6,0,0); the following samples 9, 10, 11, 12 give X=(9,10,11,12).
REQ-034 s_last on a 1st-slot sample 7 -> X=(7,0,0,0); s_last on the 4th sample of 1,1,1,1 -> exactly one vector (1,1,1,1).
REQ-035 Accept 2 samples, then assert arst for 1 cycle, then stream 3, 4, 5, 6 -> single vector (3,4,5,6), vec_count=1.
REQ-036 Run 65536 vectors at full rate -> vec_count reads 0 after the last handoff, with no sample dropped or duplicated, checked against a reference queue.
